// File: rtl/hazard_sched.sv
// ============================================================================
// Module   : hazard_sched
// Purpose  : Stall/flush/halt scheduler for the 5-stage MIPS pipeline; drives
//            PC, IF/ID and ID/EX write codes and keeps stall/flush counters.
//            Optional macro HAZARD_FORWARD_EN selects the forwarding hazard rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sched #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_dst,
  input  logic             ex_branch_taken,
  input  logic             halt_req,
  output logic [2:0]       pc_ctl,
  output logic [2:0]       ifid_ctl,
  output logic [2:0]       idex_ctl,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0]       c_RUN      = 3'b111;
  localparam logic [2:0]       c_HOLD     = 3'b010;
  localparam logic [2:0]       c_FLUSH    = 3'b000;
  localparam logic [3:0]       c_FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [3:0]       c_DRAIN_LD = 4'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_hazard;
  logic             w_unused;

  function automatic logic f_match(input logic [4:0] reg_id, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (reg_id != 5'd0) && ((use_rs && (reg_id == rs)) || (use_rt && (reg_id == rt)));
  endfunction

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; MEM results are bypassed.
  assign w_hazard = ex_regwrite && ex_memread &&
                    f_match(ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign w_unused = ^{mem_regwrite, mem_dst};
`else
  assign w_hazard = (ex_regwrite  && f_match(ex_dst,  id_rs, id_rt, id_uses_rs, id_uses_rt)) ||
                    (mem_regwrite && f_match(mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt));
  assign w_unused = ex_memread;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    pc_ctl       = c_RUN;
    ifid_ctl     = c_RUN;
    idex_ctl     = c_RUN;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (ex_branch_taken) begin
          ifid_ctl     = c_FLUSH;
          idex_ctl     = c_FLUSH;
          w_state_next = S_FLUSH;
          w_cnt_next   = c_FLUSH_LD;
          w_flush_inc  = 1'b1;
        end else if (w_hazard) begin
          pc_ctl      = c_HOLD;
          ifid_ctl    = c_HOLD;
          idex_ctl    = c_FLUSH;
          w_stall_inc = 1'b1;
        end else if (halt_req) begin
          pc_ctl       = c_HOLD;
          ifid_ctl     = c_FLUSH;
          idex_ctl     = c_FLUSH;
          w_state_next = S_DRAIN;
          w_cnt_next   = c_DRAIN_LD;
        end else if (id_jump) begin
          ifid_ctl    = c_FLUSH;
          w_flush_inc = 1'b1;
        end
      end
      S_FLUSH: begin
        // IF/ID is squashed here, so ID-stage hazards and jumps are moot.
        ifid_ctl = c_FLUSH;
        if (ex_branch_taken) begin
          idex_ctl    = c_FLUSH;
          w_cnt_next  = c_FLUSH_LD;
          w_flush_inc = 1'b1;
        end else if (r_cnt <= 4'd1) begin
          w_state_next = S_RUN;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DRAIN: begin
        pc_ctl   = c_HOLD;
        ifid_ctl = c_FLUSH;
        idex_ctl = c_FLUSH;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_HALT;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_HALT: begin
        pc_ctl   = c_HOLD;
        ifid_ctl = c_HOLD;
        idex_ctl = c_HOLD;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
    if (rst) begin
      pc_ctl   = c_FLUSH;
      ifid_ctl = c_FLUSH;
      idex_ctl = c_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign halted    = (r_state == S_HALT) && !rst;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sched.sv
// ============================================================================
// Module   : tb_hazard_sched
// Purpose  : Directed plus randomized bench for hazard_sched against a
//            remaining-cycles reference model; honours HAZARD_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_sched;

  localparam int FC = 1;
  localparam int DC = 3;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_dst, mem_dst;
  logic          id_uses_rs, id_uses_rt, id_jump;
  logic          ex_regwrite, ex_memread, mem_regwrite;
  logic          ex_branch_taken, halt_req;
  logic [2:0]    pc_ctl, ifid_ctl, idex_ctl;
  logic          halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: cycles left in each mode plus event tallies.
  int   m_flush_left, m_drain_left, m_sc, m_fc;
  bit   m_halted;
  logic [2:0] e_pc, e_ifid, e_idex;

  hazard_sched #(.FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
    .pc_ctl(pc_ctl), .ifid_ctl(ifid_ctl), .idex_ctl(idex_ctl),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit mt(input logic [4:0] r);
    return (r != 5'd0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt));
  endfunction

  function automatic bit m_hazard();
`ifdef HAZARD_FORWARD_EN
    return ex_regwrite && ex_memread && mt(ex_dst);
`else
    return (ex_regwrite && mt(ex_dst)) || (mem_regwrite && mt(mem_dst));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_regwrite = 0; ex_memread = 0; ex_dst = 0; mem_regwrite = 0; mem_dst = 0;
    ex_branch_taken = 0; halt_req = 0;
  endtask

  task automatic predict();
    if (rst) begin
      {e_pc, e_ifid, e_idex} = {3'b000, 3'b000, 3'b000};
    end else if (m_halted) begin
      {e_pc, e_ifid, e_idex} = {3'b010, 3'b010, 3'b010};
    end else if (m_drain_left > 0) begin
      {e_pc, e_ifid, e_idex} = {3'b010, 3'b000, 3'b000};
    end else if (m_flush_left > 0) begin
      e_pc = 3'b111; e_ifid = 3'b000;
      e_idex = ex_branch_taken ? 3'b000 : 3'b111;
    end else if (ex_branch_taken) begin
      {e_pc, e_ifid, e_idex} = {3'b111, 3'b000, 3'b000};
    end else if (m_hazard()) begin
      {e_pc, e_ifid, e_idex} = {3'b010, 3'b010, 3'b000};
    end else if (halt_req) begin
      {e_pc, e_ifid, e_idex} = {3'b010, 3'b000, 3'b000};
    end else if (id_jump) begin
      {e_pc, e_ifid, e_idex} = {3'b111, 3'b000, 3'b111};
    end else begin
      {e_pc, e_ifid, e_idex} = {3'b111, 3'b111, 3'b111};
    end
  endtask

  task automatic update();
    if (rst) begin
      m_flush_left = 0; m_drain_left = 0; m_sc = 0; m_fc = 0; m_halted = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (m_flush_left > 0) begin
      if (ex_branch_taken) begin
        m_flush_left = FC;
        if (m_fc < SAT) m_fc++;
      end else begin
        m_flush_left--;
      end
    end else if (ex_branch_taken) begin
      m_flush_left = FC;
      if (m_fc < SAT) m_fc++;
    end else if (m_hazard()) begin
      if (m_sc < SAT) m_sc++;
    end else if (halt_req) begin
      m_drain_left = DC;
    end else if (id_jump) begin
      if (m_fc < SAT) m_fc++;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    predict();
    @(negedge clk);
    chk("pc_ctl", pc_ctl, e_pc);
    chk("ifid_ctl", ifid_ctl, e_ifid);
    chk("idex_ctl", idex_ctl, e_idex);
    chk("halted", halted, (!rst && m_halted) ? 1 : 0);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    m_flush_left = 0; m_drain_left = 0; m_sc = 0; m_fc = 0; m_halted = 0;
    clear_in();
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_codes", {pc_ctl, ifid_ctl, idex_ctl}, 9'b000_000_000);
    rst = 1'b0;
    cycle();
    chk("post_rst_codes", {pc_ctl, ifid_ctl, idex_ctl}, 9'b111_111_111);
    chk("post_rst_cnts", {stall_cnt, flush_cnt}, 0);

`ifdef HAZARD_FORWARD_EN
    ex_regwrite = 1; ex_memread = 1; ex_dst = 8; id_rs = 8; id_uses_rs = 1;
    cycle();
    clear_in();
    cycle();
    chk("loaduse_stall_cnt", stall_cnt, 1);
    ex_regwrite = 1; ex_memread = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1;
    cycle();
    chk("r0_no_stall", stall_cnt, 1);
    clear_in();
`else
    ex_regwrite = 1; ex_dst = 9; id_rt = 9; id_uses_rt = 1;
    cycle();
    ex_regwrite = 0; mem_regwrite = 1; mem_dst = 9;
    cycle();
    clear_in();
    cycle();
    chk("raw_stall_cnt", stall_cnt, 2);
`endif

    do_reset();
    ex_regwrite = 1; ex_memread = 1; ex_dst = 9; id_rt = 9; id_uses_rt = 1;
    cycle();
    ex_branch_taken = 1;
    predict();
    @(negedge clk);
    chk("br_stall_codes", {pc_ctl, ifid_ctl, idex_ctl}, 9'b111_000_000);
    @(posedge clk); update(); #1;
    clear_in();
    cycle();
    cycle();
    chk("br_back_run", {pc_ctl, ifid_ctl, idex_ctl}, 9'b111_111_111);
    chk("br_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd1});

    do_reset();
    id_jump = 1;
    cycle();
    clear_in();
    cycle();
    chk("jump_flush_cnt", flush_cnt, 1);

    do_reset();
    halt_req = 1;
    cycle();
    clear_in();
    for (int i = 0; i < DC; i++) cycle();
    for (int i = 0; i < 10; i++) cycle();
    chk("halted_codes", {halted, pc_ctl, ifid_ctl, idex_ctl}, 10'b1_010_010_010);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("unhalt", {halted, pc_ctl}, 4'b0_111);

    do_reset();
    ex_regwrite = 1; ex_memread = 1; ex_dst = 3; id_rs = 3; id_uses_rs = 1;
    for (int i = 0; i < SAT + 4; i++) cycle();
    chk("stall_sat", stall_cnt, SAT);
    clear_in();
    id_jump = 1;
    for (int i = 0; i < SAT + 4; i++) cycle();
    chk("flush_sat", flush_cnt, SAT);

    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_dst = 5'($urandom_range(0, 3));
      mem_dst = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 29) == 0);
      id_jump = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

`default_nettype wire
